condlogic_it: RTL and testbench

CONDLOGIC_IT -- requirements
Module: condlogic_it

---
 rtl/condlogic_pkg.sv | 34 +++
 rtl/condlogic_it_cond_eval.sv | 41 ++++
 rtl/condlogic_it.sv | 189 ++++++++++++++++++
 tb/tb_condlogic_it.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/condlogic_pkg.sv
// Shared types and constants for the condition-logic block: ARM condition
// codes, predicated-block FSM states and flag bit positions within {N,Z,C,V}.
package condlogic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_it_cond_eval.sv
// Purely combinational ARM condition-code evaluator: pass = Cond holds for Flags.
module cond_eval
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = Flags[FLAG_N];
  assign z_s = Flags[FLAG_Z];
  assign c_s = Flags[FLAG_C];
  assign v_s = Flags[FLAG_V];

  // Decode the condition field against the four flags
  always_comb begin
    pass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_it.sv
// Conditional-execution logic with per-context flags and an optional
// IT-style predicated block. The predicated block (FSM, ItStart/ItCond/ItLen)
// is built only when macro CONDLOGIC_IT_EN is defined; otherwise the It*
// inputs are ignored and ItActive/ItErr are tied low.
module condlogic_it
  import condlogic_pkg::*;
#(
  parameter int NCTX  = 2,
  parameter int ITLEN = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     Valid,
  input  logic [((NCTX > 1) ? $clog2(NCTX) : 1)-1:0] Ctx,
  input  logic [3:0]                               Cond,
  input  logic [3:0]                               ALUFlags,
  input  logic [1:0]                               FlagW,
  input  logic                                     PCS,
  input  logic                                     RegW,
  input  logic                                     MemW,
  input  logic                                     ItStart,
  input  logic [3:0]                               ItCond,
  input  logic [$clog2(ITLEN+1)-1:0]               ItLen,
  output logic                                     PCSrc,
  output logic                                     RegWrite,
  output logic                                     MemWrite,
  output logic                                     CondEx,
  output logic                                     ItActive,
  output logic                                     ItErr,
  output logic [3:0]                               Flags
);

  localparam int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam int NCTXP = 2 ** CTXW;
  localparam int LENW  = $clog2(ITLEN + 1);

  logic [3:0] flags_r [NCTXP];
  logic [3:0] flags_s;
  logic       ctx_ok_s;
  logic       pass_s;
  logic       pass_it_s;
  logic       in_block_s;
  logic [3:0] it_cond_s;

  // Contexts beyond NCTX (non power-of-two counts) read as zero and are never written
  assign ctx_ok_s = (int'(Ctx) < NCTX);

  // Select the registered flags of the instruction's context
  always_comb begin
    if (ctx_ok_s) begin
      flags_s = flags_r[Ctx];
    end else begin
      flags_s = 4'b0000;
    end
  end

  assign Flags = flags_s;

  cond_eval u_cond_instr (
    .Cond  (Cond),
    .Flags (flags_s),
    .pass  (pass_s)
  );

  cond_eval u_cond_block (
    .Cond  (it_cond_s),
    .Flags (flags_s),
    .pass  (pass_it_s)
  );

  assign CondEx   = Valid & pass_s & (~in_block_s | pass_it_s);
  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;

  // Per-context flag storage; N,Z and C,V halves are written independently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCTXP; i++) begin
        flags_r[i] <= 4'b0000;
      end
    end else if (ctx_ok_s) begin
      if (FlagW[1] && CondEx) begin
        flags_r[Ctx][FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (FlagW[0] && CondEx) begin
        flags_r[Ctx][FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

`ifdef CONDLOGIC_IT_EN

  localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
  localparam logic [LENW-1:0] LEN_ZERO = LENW'(0);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(ITLEN);

  it_state_e         state_r;
  it_state_e         state_n;
  logic [LENW-1:0]   cnt_r;
  logic [3:0]        it_cond_r;
  logic [CTXW-1:0]   it_ctx_r;
  logic              it_err_r;
  logic              start_ok_s;
  logic              err_s;
  logic              in_ctx_s;

  assign start_ok_s = Valid & ItStart & (ItLen != LEN_ZERO) & (ItLen <= LEN_MAX);
  assign in_block_s = ItActive & (Ctx == it_ctx_r);
  assign in_ctx_s   = Valid & in_block_s;
  assign it_cond_s  = it_cond_r;

  // Error when opening an oversize block or attempting to nest one
  assign err_s = Valid & ItStart & ((state_r == IT_ACTIVE) | (ItLen > LEN_MAX));

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IT_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state: open on a legal start, close on count exhaustion or a taken branch
  always_comb begin
    state_n = state_r;
    case (state_r)
      IT_IDLE: begin
        if (start_ok_s) begin
          state_n = IT_ACTIVE;
        end else begin
          state_n = IT_IDLE;
        end
      end
      IT_ACTIVE: begin
        if (in_ctx_s && (PCSrc || (cnt_r == LEN_ONE))) begin
          state_n = IT_IDLE;
        end else begin
          state_n = IT_ACTIVE;
        end
      end
      default: state_n = IT_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ItActive = (state_r == IT_ACTIVE);
    ItErr    = it_err_r;
  end

  // Block context: latch condition, owner context and length; count owner instructions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= LEN_ZERO;
      it_cond_r <= 4'b0000;
      it_ctx_r  <= '0;
    end else if ((state_r == IT_IDLE) && start_ok_s) begin
      cnt_r     <= ItLen;
      it_cond_r <= ItCond;
      it_ctx_r  <= Ctx;
    end else if ((state_r == IT_ACTIVE) && in_ctx_s) begin
      cnt_r <= cnt_r - LEN_ONE;
    end
  end

  // One-cycle error pulse, registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      it_err_r <= 1'b0;
    end else begin
      it_err_r <= err_s;
    end
  end

`else

  logic unused_it_s;

  assign in_block_s  = 1'b0;
  assign it_cond_s   = 4'b0000;
  assign ItActive    = 1'b0;
  assign ItErr       = 1'b0;
  assign unused_it_s = ^{ItStart, ItCond, ItLen, pass_it_s};

`endif

endmodule

// File: tb/tb_condlogic_it.sv
// Directed, table-driven bench for condlogic_it (NCTX=2, ITLEN=4).
// Predicated-block sequences are exercised when CONDLOGIC_IT_EN is defined.
`timescale 1ns/1ps
module tb_condlogic_it;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Valid;
  logic [0:0] Ctx;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       ItStart;
  logic [3:0] ItCond;
  logic [2:0] ItLen;
  logic       PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItErr;
  logic [3:0] Flags;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       valid;
    logic       ctx;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       exp_condex;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs [21];

  condlogic_it #(.NCTX(2), .ITLEN(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Valid    (Valid),
    .Ctx      (Ctx),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .ItStart  (ItStart),
    .ItCond   (ItCond),
    .ItLen    (ItLen),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .ItActive (ItActive),
    .ItErr    (ItErr),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction at the negative edge; outputs settle 1ns later
  task automatic step(input logic v, input logic c, input logic [3:0] cd,
                      input logic [3:0] alu, input logic [1:0] fw,
                      input logic pcs, input logic regw, input logic memw,
                      input logic its, input logic [3:0] itc, input logic [2:0] itl);
    @(negedge clk);
    Valid = v; Ctx = c; Cond = cd; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw;
    ItStart = its; ItCond = itc; ItLen = itl;
    #1;
  endtask

  task automatic set_vec(input int i, input logic v, input logic c, input logic [3:0] cd,
                         input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                         input logic regw, input logic memw, input logic ec,
                         input logic [3:0] ef);
    vecs[i] = '{v, c, cd, alu, fw, pcs, regw, memw, ec, ef};
  endtask

  initial begin
    // valid ctx cond alu flagw pcs regw memw | condex flags(before edge)
    set_vec( 0, 1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 1'b0, 4'b0000); // EQ, Z=0
    set_vec( 1, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1'b1, 4'b0000); // AL
    set_vec( 2, 1, 0, 4'hE, 4'h4, 2'b11, 0, 0, 0, 1'b1, 4'b0000); // ctx0 <= 0100
    set_vec( 3, 1, 1, 4'h0, 4'h0, 2'b00, 0, 1, 1, 1'b0, 4'b0000); // ctx1 EQ fails
    set_vec( 4, 1, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 1'b1, 4'b0100); // ctx0 EQ passes
    set_vec( 5, 1, 0, 4'hE, 4'hB, 2'b01, 0, 0, 0, 1'b1, 4'b0100); // C,V only -> 0111
    set_vec( 6, 1, 0, 4'h8, 4'h0, 2'b11, 1, 1, 1, 1'b0, 4'b0111); // HI fails, no write
    set_vec( 7, 1, 0, 4'h9, 4'h0, 2'b00, 0, 1, 0, 1'b1, 4'b0111); // LS
    set_vec( 8, 1, 0, 4'hB, 4'h8, 2'b10, 0, 1, 0, 1'b1, 4'b0111); // LT, N,Z -> 1011
    set_vec( 9, 1, 0, 4'hA, 4'h0, 2'b00, 0, 0, 1, 1'b1, 4'b1011); // GE
    set_vec(10, 1, 0, 4'hC, 4'h0, 2'b00, 1, 0, 0, 1'b1, 4'b1011); // GT
    set_vec(11, 1, 0, 4'hF, 4'h0, 2'b11, 1, 1, 1, 1'b0, 4'b1011); // NV
    set_vec(12, 0, 0, 4'hE, 4'h0, 2'b11, 1, 1, 1, 1'b0, 4'b1011); // not valid
    set_vec(13, 1, 1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 1'b1, 4'b0000); // ctx1 NE
    set_vec(14, 1, 1, 4'h3, 4'h3, 2'b01, 0, 0, 0, 1'b1, 4'b0000); // CC, ctx1 -> 0011
    set_vec(15, 1, 1, 4'h2, 4'h0, 2'b00, 0, 0, 1, 1'b1, 4'b0011); // CS
    set_vec(16, 1, 1, 4'h4, 4'h0, 2'b00, 0, 1, 0, 1'b0, 4'b0011); // MI fails
    set_vec(17, 1, 1, 4'h6, 4'h0, 2'b00, 0, 1, 0, 1'b1, 4'b0011); // VS
    set_vec(18, 1, 0, 4'hD, 4'h0, 2'b00, 0, 1, 0, 1'b0, 4'b1011); // LE fails
    set_vec(19, 1, 0, 4'h5, 4'h0, 2'b00, 0, 1, 0, 1'b0, 4'b1011); // PL fails
    set_vec(20, 1, 1, 4'h7, 4'h0, 2'b00, 0, 1, 0, 1'b0, 4'b0011); // VC fails

    reset_n = 1'b0;
    Valid = 1'b0; Ctx = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    ItStart = 1'b0; ItCond = 4'h0; ItLen = 3'd0;
    #2;
    chk("rst itactive", {3'b000, ItActive}, 4'h0);
    chk("rst iterr",    {3'b000, ItErr},    4'h0);
    chk("rst flags",    Flags,              4'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].valid, vecs[i].ctx, vecs[i].cond, vecs[i].alu, vecs[i].flagw,
           vecs[i].pcs, vecs[i].regw, vecs[i].memw, 1'b0, 4'h0, 3'd0);
      chk($sformatf("v%0d condex", i),   {3'b000, CondEx},   {3'b000, vecs[i].exp_condex});
      chk($sformatf("v%0d pcsrc", i),    {3'b000, PCSrc},    {3'b000, vecs[i].pcs  & vecs[i].exp_condex});
      chk($sformatf("v%0d regwrite", i), {3'b000, RegWrite}, {3'b000, vecs[i].regw & vecs[i].exp_condex});
      chk($sformatf("v%0d memwrite", i), {3'b000, MemWrite}, {3'b000, vecs[i].memw & vecs[i].exp_condex});
      chk($sformatf("v%0d flags", i),    Flags,              vecs[i].exp_flags);
    end
    // flags now: ctx0 = 1011, ctx1 = 0011

`ifdef CONDLOGIC_IT_EN
    // Block of 3 with EQ, Z=1; a foreign-context instruction in the middle
    step(1, 0, 4'hE, 4'h4, 2'b10, 0, 0, 0, 0, 4'h0, 3'd0);     // ctx0 -> 0111
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1, 4'h0, 3'd3);     // IT EQ, 3
    chk("a start unpred", {3'b000, CondEx}, 4'h1);
    chk("a idle before",  {3'b000, ItActive}, 4'h0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("a i1 active", {3'b000, ItActive}, 4'h1);
    chk("a i1 condex", {3'b000, CondEx}, 4'h1);
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);     // ctx1: EQ would fail
    chk("a foreign unpred", {3'b000, RegWrite}, 4'h1);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("a i2 active", {3'b000, ItActive}, 4'h1);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("a i3 active", {3'b000, ItActive}, 4'h1);
    chk("a i3 condex", {3'b000, CondEx}, 4'h1);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("a i4 idle",   {3'b000, ItActive}, 4'h0);
    chk("a i4 condex", {3'b000, CondEx}, 4'h1);

    // Block of 2; first instruction clears Z, second must fail
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd2);
    step(1, 0, 4'hE, 4'h0, 2'b10, 0, 1, 0, 0, 4'h0, 3'd0);     // ctx0 -> 0011
    chk("b i1 condex", {3'b000, CondEx}, 4'h1);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("b i2 active",   {3'b000, ItActive}, 4'h1);
    chk("b i2 condex",   {3'b000, CondEx}, 4'h0);
    chk("b i2 regwrite", {3'b000, RegWrite}, 4'h0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("b after idle",  {3'b000, ItActive}, 4'h0);
    chk("b after condex", {3'b000, CondEx}, 4'h1);

    // Block of 4 ended early by a taken branch
    step(1, 0, 4'hE, 4'h4, 2'b10, 0, 0, 0, 0, 4'h0, 3'd0);     // ctx0 -> 0111
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd4);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 3'd0);
    chk("c branch pcsrc", {3'b000, PCSrc}, 4'h1);
    chk("c branch active", {3'b000, ItActive}, 4'h1);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("c branch exit", {3'b000, ItActive}, 4'h0);

    // Nested start: error pulse, still predicated and counted
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd4);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1, 4'h1, 3'd2);
    chk("n nest condex", {3'b000, CondEx}, 4'h1);
    chk("n nest err0",   {3'b000, ItErr}, 4'h0);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("n err pulse",   {3'b000, ItErr}, 4'h1);
    chk("n still active", {3'b000, ItActive}, 4'h1);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("n err end", {3'b000, ItErr}, 4'h0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("n last active", {3'b000, ItActive}, 4'h1);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("n counted exit", {3'b000, ItActive}, 4'h0);

    // Oversize and zero-length starts
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd5);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("e big err",    {3'b000, ItErr}, 4'h1);
    chk("e big idle",   {3'b000, ItActive}, 4'h0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd0);
    chk("e big err end", {3'b000, ItErr}, 4'h0);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("e zero idle",  {3'b000, ItActive}, 4'h0);
    chk("e zero noerr", {3'b000, ItErr}, 4'h0);

    // Leave a ctx1 block open for the reset check below
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h2, 3'd4);
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("r pre active", {3'b000, ItActive}, 4'h1);
`else
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1, 4'h0, 3'd3);
    chk("d start condex", {3'b000, CondEx}, 4'h1);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd5);
    chk("d no active", {3'b000, ItActive}, 4'h0);
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0);
    chk("d no err", {3'b000, ItErr}, 4'h0);
`endif

    // Asynchronous reset with flags set (mid-block when the block is built)
    step(1, 0, 4'hE, 4'h4, 2'b10, 0, 0, 0, 0, 4'h0, 3'd0);     // ctx0 -> 0111
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);     // ctx0 EQ
    chk("r pre condex", {3'b000, CondEx}, 4'h1);
    chk("r pre flags",  Flags, 4'b0111);
    reset_n = 1'b0;
    #1;
    chk("r flags",    Flags, 4'h0);
    chk("r condex",   {3'b000, CondEx}, 4'h0);
    chk("r regwrite", {3'b000, RegWrite}, 4'h0);
    chk("r active",   {3'b000, ItActive}, 4'h0);
    chk("r err",      {3'b000, ItErr}, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("r post al", {3'b000, CondEx}, 4'h1);
    chk("r post active", {3'b000, ItActive}, 4'h0);
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0);
    chk("r post eq", {3'b000, CondEx}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
